// File: rtl/alarm_pkg.sv
// Shared encodings and field widths for the alarm path.
package alarm_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned DAY_W      = 3;
    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MIN_W      = 6;
    localparam int unsigned SEC_W      = 6;
    localparam int unsigned SNZ_TMR_W  = 10;
    localparam int unsigned RING_TMR_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RINGING = 3'd2,
        SNOOZE  = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for an already-synchronised, debounced button level.
// A button held through reset yields no edge: detection is only enabled once
// the history flop has sampled the real input level.
module button_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic In,
    output logic Rise
);

    logic prev_q;
    logic valid_q;

    // Track one cycle of input history; enable detection after first sample.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= In;
            valid_q <= 1'b1;
        end
    end

    assign Rise = valid_q && In && !prev_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms, matches day/hour/minute, rings with a beep pattern,
// and handles bounded snooze, stop, ring timeout and same-minute lockout.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 9,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               AlarmSet,
    input  logic               Snooze,
    input  logic               Stop,
    input  logic [DAY_W-1:0]   CurDay,
    input  logic [HOUR_W-1:0]  CurHour,
    input  logic [MIN_W-1:0]   CurMin,
    input  logic [SEC_W-1:0]   CurSec,
    input  logic [6:0]         AlarmDays,
    input  logic [HOUR_W-1:0]  AlarmHour,
    input  logic [MIN_W-1:0]   AlarmMin,
    output logic               Buzz,
    output logic               Ringing,
    output logic               Snoozing,
    output logic [1:0]         SnoozeCnt,
    output logic [STATE_W-1:0] State
);

    localparam logic [SNZ_TMR_W-1:0]  SnzLoad  = SNZ_TMR_W'(SNOOZE_MIN * 60);
    localparam logic [RING_TMR_W-1:0] RingLoad = RING_TMR_W'(RING_SEC);
    localparam logic [1:0]            MaxSnz   = 2'(MAX_SNOOZE);

    logic snooze_e;
    logic stop_e;

    button_edge u_snooze_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Snooze),
        .Rise  (snooze_e)
    );

    button_edge u_stop_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Stop),
        .Rise  (stop_e)
    );

    state_e                 state_q, state_d;
    logic [RING_TMR_W-1:0]  ring_tmr_q, ring_tmr_d;
    logic [SNZ_TMR_W-1:0]   snz_tmr_q, snz_tmr_d;
    logic [1:0]             snz_cnt_q, snz_cnt_d;
    logic                   beep_q, beep_d;
    logic                   ringing_q, snoozing_q, buzz_q;

    // Day mask padded so a stray CurDay of 7 selects a disabled bit.
    logic [7:0] days_ext;
    logic       same_hm;
    logic       match;

    // Time compare against the stored alarm.
    always_comb begin
        days_ext = {1'b0, AlarmDays};
        same_hm  = (CurHour == AlarmHour) && (CurMin == AlarmMin);
        match    = days_ext[CurDay] && same_hm && (CurSec == '0);
    end

    // Next-state, timer and snooze-count logic.
    always_comb begin
        state_d    = state_q;
        ring_tmr_d = ring_tmr_q;
        snz_tmr_d  = snz_tmr_q;
        snz_cnt_d  = snz_cnt_q;
        beep_d     = beep_q;

        if (!AlarmSet) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
            beep_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;

                ARMED: begin
                    if (Tick && match) begin
                        state_d    = RINGING;
                        ring_tmr_d = RingLoad;
                        snz_cnt_d  = '0;
                        beep_d     = 1'b1;
                    end
                end

                RINGING: begin
                    if (stop_e) begin
                        state_d = LOCKOUT;
                    end else if (snooze_e && (snz_cnt_q < MaxSnz)) begin
                        state_d   = SNOOZE;
                        snz_tmr_d = SnzLoad;
                        snz_cnt_d = snz_cnt_q + 2'd1;
                    end else if (Tick) begin
                        beep_d = !beep_q;
                        if (ring_tmr_q <= RING_TMR_W'(1)) begin
                            state_d    = LOCKOUT;
                            ring_tmr_d = '0;
                        end else begin
                            ring_tmr_d = ring_tmr_q - RING_TMR_W'(1);
                        end
                    end
                end

                SNOOZE: begin
                    if (stop_e) begin
                        state_d = LOCKOUT;
                    end else if (Tick) begin
                        if (snz_tmr_q <= SNZ_TMR_W'(1)) begin
                            state_d    = RINGING;
                            snz_tmr_d  = '0;
                            ring_tmr_d = RingLoad;
                            beep_d     = 1'b1;
                        end else begin
                            snz_tmr_d = snz_tmr_q - SNZ_TMR_W'(1);
                        end
                    end
                end

                // Hold off until the alarm minute has passed to avoid retrigger.
                LOCKOUT: begin
                    if (Tick && !same_hm) begin
                        state_d   = ARMED;
                        snz_cnt_d = '0;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State, timers and registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            ring_tmr_q <= '0;
            snz_tmr_q  <= '0;
            snz_cnt_q  <= '0;
            beep_q     <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_tmr_q <= ring_tmr_d;
            snz_tmr_q  <= snz_tmr_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_q     <= beep_d;
            ringing_q  <= (state_d == RINGING);
            snoozing_q <= (state_d == SNOOZE);
            buzz_q     <= (state_d == RINGING) && beep_d;
        end
    end

    assign Buzz      = buzz_q;
    assign Ringing   = ringing_q;
    assign Snoozing  = snoozing_q;
    assign SnoozeCnt = snz_cnt_q;
    assign State     = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default parameters
// (9 min snooze = 540 ticks, 60 s ring, 3 snoozes).
module tb_alarm_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Tick;
    logic       AlarmSet;
    logic       Snooze;
    logic       Stop;
    logic [2:0] CurDay;
    logic [4:0] CurHour;
    logic [5:0] CurMin;
    logic [5:0] CurSec;
    logic [6:0] AlarmDays;
    logic [4:0] AlarmHour;
    logic [5:0] AlarmMin;
    logic       Buzz;
    logic       Ringing;
    logic       Snoozing;
    logic [1:0] SnoozeCnt;
    logic [2:0] State;

    int n_assert = 0;
    int n_fail   = 0;

    alarm_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .AlarmSet  (AlarmSet),
        .Snooze    (Snooze),
        .Stop      (Stop),
        .CurDay    (CurDay),
        .CurHour   (CurHour),
        .CurMin    (CurMin),
        .CurSec    (CurSec),
        .AlarmDays (AlarmDays),
        .AlarmHour (AlarmHour),
        .AlarmMin  (AlarmMin),
        .Buzz      (Buzz),
        .Ringing   (Ringing),
        .Snoozing  (Snoozing),
        .SnoozeCnt (SnoozeCnt),
        .State     (State)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            @(posedge Clk);
            #1;
            Tick = 1'b0;
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Tick      = 1'b0;
        AlarmSet  = 1'b0;
        Snooze    = 1'b0;
        Stop      = 1'b0;
        AlarmDays = 7'b0000100;
        AlarmHour = 5'd7;
        AlarmMin  = 6'd30;
        CurDay    = 3'd2;
        CurHour   = 5'd7;
        CurMin    = 6'd29;
        CurSec    = 6'd0;
        #12;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_buzz", 32'(Buzz), 32'd0);
        chk("rst_ringing", 32'(Ringing), 32'd0);
        chk("rst_snoozing", 32'(Snoozing), 32'd0);
        chk("rst_cnt", 32'(SnoozeCnt), 32'd0);

        Reset    = 1'b0;
        AlarmSet = 1'b1;
        clk1();
        chk("arm", 32'(State), 32'd1);

        // Wrong day, then nonzero seconds: no ring.
        CurDay = 3'd3;
        CurMin = 6'd30;
        tick_n(1);
        chk("wrong_day", 32'(State), 32'd1);
        CurDay = 3'd2;
        CurSec = 6'd5;
        tick_n(1);
        chk("sec_nonzero", 32'(State), 32'd1);

        // Event A: ring until timeout.
        CurSec = 6'd0;
        tick_n(1);
        chk("a_ring_state", 32'(State), 32'd2);
        chk("a_ringing", 32'(Ringing), 32'd1);
        chk("a_buzz0", 32'(Buzz), 32'd1);
        tick_n(1);
        chk("a_buzz1", 32'(Buzz), 32'd0);
        tick_n(1);
        chk("a_buzz2", 32'(Buzz), 32'd1);
        tick_n(57);
        chk("a_tick59", 32'(State), 32'd2);
        tick_n(1);
        chk("a_timeout", 32'(State), 32'd4);
        chk("a_timeout_buzz", 32'(Buzz), 32'd0);
        chk("a_timeout_ringing", 32'(Ringing), 32'd0);
        tick_n(1);
        chk("a_lock_same_min", 32'(State), 32'd4);
        CurMin = 6'd31;
        tick_n(1);
        chk("a_rearm", 32'(State), 32'd1);

        // Event B: one snooze, then Stop and Snooze together.
        CurMin = 6'd30;
        tick_n(1);
        chk("b_ring", 32'(State), 32'd2);
        Snooze = 1'b1;
        clk1();
        Snooze = 1'b0;
        chk("b_snooze", 32'(State), 32'd3);
        chk("b_snoozing", 32'(Snoozing), 32'd1);
        chk("b_cnt1", 32'(SnoozeCnt), 32'd1);
        chk("b_snz_buzz", 32'(Buzz), 32'd0);
        tick_n(539);
        chk("b_snz_539", 32'(State), 32'd3);
        tick_n(1);
        chk("b_resume", 32'(State), 32'd2);
        chk("b_resume_buzz", 32'(Buzz), 32'd1);
        chk("b_resume_cnt", 32'(SnoozeCnt), 32'd1);
        Snooze = 1'b1;
        Stop   = 1'b1;
        clk1();
        Snooze = 1'b0;
        Stop   = 1'b0;
        chk("b_stop_wins", 32'(State), 32'd4);
        chk("b_stop_cnt", 32'(SnoozeCnt), 32'd1);
        clk1();
        CurMin = 6'd31;
        tick_n(1);
        chk("b_rearm", 32'(State), 32'd1);
        chk("b_rearm_cnt", 32'(SnoozeCnt), 32'd0);

        // Event C: exhaust snoozes; the fourth is ignored.
        CurMin = 6'd30;
        tick_n(1);
        for (int k = 1; k <= 3; k++) begin
            Snooze = 1'b1;
            clk1();
            Snooze = 1'b0;
            chk("c_snooze", 32'(State), 32'd3);
            chk("c_cnt", 32'(SnoozeCnt), 32'(k));
            tick_n(540);
            chk("c_resume", 32'(State), 32'd2);
        end
        Snooze = 1'b1;
        clk1();
        Snooze = 1'b0;
        chk("c_4th_state", 32'(State), 32'd2);
        chk("c_4th_ringing", 32'(Ringing), 32'd1);
        chk("c_4th_cnt", 32'(SnoozeCnt), 32'd3);
        Stop = 1'b1;
        clk1();
        Stop = 1'b0;
        chk("c_stop", 32'(State), 32'd4);
        clk1();
        CurMin = 6'd31;
        tick_n(1);
        chk("c_rearm", 32'(State), 32'd1);

        // Event D: snooze on the expiring tick wins, then AlarmSet dropped.
        CurMin = 6'd30;
        tick_n(1);
        tick_n(59);
        chk("d_last_sec", 32'(State), 32'd2);
        Snooze = 1'b1;
        tick_n(1);
        Snooze = 1'b0;
        chk("d_snz_wins", 32'(State), 32'd3);
        chk("d_cnt", 32'(SnoozeCnt), 32'd1);
        tick_n(5);
        AlarmSet = 1'b0;
        clk1();
        chk("d_off_state", 32'(State), 32'd0);
        chk("d_off_cnt", 32'(SnoozeCnt), 32'd0);
        chk("d_off_snoozing", 32'(Snoozing), 32'd0);

        // Event E: async reset mid-ring; held button gives no edge afterwards.
        AlarmSet = 1'b1;
        clk1();
        chk("e_arm", 32'(State), 32'd1);
        tick_n(1);
        chk("e_ring_buzz", 32'(Buzz), 32'd1);
        #2;
        Reset  = 1'b1;
        Snooze = 1'b1;
        #1;
        chk("e_rst_state", 32'(State), 32'd0);
        chk("e_rst_buzz", 32'(Buzz), 32'd0);
        chk("e_rst_ringing", 32'(Ringing), 32'd0);
        clk1();
        Reset = 1'b0;
        clk1();
        chk("e_rearm", 32'(State), 32'd1);
        tick_n(1);
        chk("e_held_no_edge", 32'(State), 32'd2);
        chk("e_held_snoozing", 32'(Snoozing), 32'd0);
        Snooze = 1'b0;
        clk1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Sequences the alarm path of the clock: arms on AlarmSet, fires when current day/hour/minute match the stored alarm, and drives the buzzer.
- Handles bounded snooze, stop and ring timeout.
- Sits beside the time-keeping control unit. Consumes its 1 Hz Tick and current-time registers. Drives the buzzer and the status LEDs.

Parameters:
- SNOOZE_MIN, 9, snooze length in minutes (1..15).
- RING_SEC, 60, seconds of ringing before auto-stop (1..255).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Tick  in  1  one-Clk-wide pulse, once per second.
- AlarmSet  in  1  alarm enable switch, level.
- Snooze  in  1  snooze button, level, synchronised/debounced upstream.
- Stop  in  1  stop button, level, synchronised/debounced upstream.
- CurDay  in  3  day of week, 0..6.
- CurHour  in  5  0..23.
- CurMin  in  6  0..59.
- CurSec  in  6  0..59.
- AlarmDays  in  7  day mask; bit d enables day d.
- AlarmHour  in  5  alarm hour.
- AlarmMin  in  6  alarm minute.
- Buzz  out  1  buzzer drive, beeping pattern.
- Ringing  out  1  high in RINGING.
- Snoozing  out  1  high in SNOOZE.
- SnoozeCnt  out  2  snoozes used in the current event.
- State  out  3  FSM state, for debug.

Behaviour:
- Reset (async, active-high): state IDLE. Buzz, Ringing, Snoozing, SnoozeCnt, State all 0. Timers 0. Edge-detect registers 0.
- All outputs registered; they reflect the new state one Clk after the transition condition.
- Edges: SnoozeE/StopE are rising edges of Snooze/Stop, from a one-flop history. A button held through reset produces no edge.
- Match: AlarmDays[CurDay] && CurHour==AlarmHour && CurMin==AlarmMin && CurSec==0. Evaluated only in a Tick cycle.
- States: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3, LOCKOUT=4. Codes 5..7 return to IDLE.
- Global rule: AlarmSet==0 in any state -> IDLE next cycle, SnoozeCnt cleared. This has the highest priority.
- IDLE: AlarmSet -> ARMED.
- ARMED: Tick && Match -> RINGING. Load RingTmr=RING_SEC, SnoozeCnt=0.
- RINGING, priority in order:
  - StopE -> LOCKOUT.
  - SnoozeE && SnoozeCnt<MAX_SNOOZE -> SNOOZE. Load SnzTmr=SNOOZE_MIN*60, SnoozeCnt+1.
  - SnoozeE with SnoozeCnt==MAX_SNOOZE is ignored; ringing continues.
  - Tick: RingTmr-1. A Tick with RingTmr==1 -> LOCKOUT (timeout).
- SNOOZE:
  - StopE -> LOCKOUT.
  - Tick: SnzTmr-1. A Tick with SnzTmr==1 -> RINGING, reload RingTmr=RING_SEC. SnoozeCnt is kept.
  - SnoozeE is ignored.
- LOCKOUT: Tick with (CurHour,CurMin)!=(AlarmHour,AlarmMin) -> ARMED, SnoozeCnt=0. This prevents a same-minute retrigger.
- Buzz: BeepPh set to 1 on every entry to RINGING, toggled on each Tick while in RINGING. Buzz = Ringing && BeepPh. Buzz is 0 in all other states.
- Simultaneous events:
  - StopE and SnoozeE in the same cycle: Stop wins.
  - Tick that expires RingTmr in the same cycle as SnoozeE: snooze wins if allowed.
  - Tick in the same cycle as a button edge: the button decision applies and the timer is loaded, not decremented.
- Timers: 10-bit SnzTmr (max 900), 8-bit RingTmr. No wrap-around; decrement occurs only while in the owning state.
- Reset mid-ring or mid-snooze: immediate IDLE, buzzer off within the same cycle (async).

Decomposition:
- Shared package alarm_pkg holds:
  - state encoding constants IDLE..LOCKOUT and STATE_W=3;
  - widths DAY_W=3, HOUR_W=5, MIN_W=6, SEC_W=6, SNZ_TMR_W=10, RING_TMR_W=8.
- One natural sub-module: button_edge (Clk, Reset, In -> Rise), instantiated for Snooze and Stop.
- The FSM, timers and match compare live in alarm_sequencer.

Test Plan:
- Reset=1 mid-ring -> State=0, Buzz=0 immediately. Release; AlarmSet=1 -> State=1 after 1 Clk.
- Alarm 07:30, mask bit 2, CurDay=2. Tick at 07:30:00 -> State=2, Ringing=1, Buzz=1. Buzz toggles every Tick. After 60 Ticks -> State=4. Next Tick at 07:31 -> State=1.
- CurDay=3 with the same time -> no ring, State stays 1.
- While ringing, Snooze edge -> State=3, SnoozeCnt=1. After 540 Ticks -> State=2. Repeat until SnoozeCnt=3; a 4th Snooze edge is ignored, Ringing stays 1.
- Snooze and Stop rise in the same cycle -> State=4, SnoozeCnt unchanged.
- AlarmSet dropped during SNOOZE -> State=0 next cycle, SnoozeCnt=0, Snoozing=0.
